pacman_move_ctrl: RTL and testbench

- Sequences Pac-Man movement from the keypad direction register (4-bit one-hot LEDS output) and a game tick.
- On each tick it first tries the newest requested direction; if that cell is a wall, it tries the current heading.
- Wall checks go over a req/ack handshake to the shared maze lookup, so the ghost logic can share that resource.
- Outputs the player position to the LED-matrix renderer.

---
 rtl/pacman_pkg.sv | 50 +++++
 rtl/pacman_move_ctrl_dir_sync.sv | 41 ++++
 rtl/pacman_move_ctrl.sv | 154 +++++++++++++++
 tb/tb_pacman_move_ctrl.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/pacman_pkg.sv
// Shared types for the Pac-Man movement block: direction encoding, FSM states, neighbour arithmetic.
// Latency: n/a (types and a pure combinational helper).
// Backpressure: n/a.
package pacman_pkg;

  typedef logic [3:0] dir_t;

  localparam dir_t DIR_N = 4'b0001;
  localparam dir_t DIR_E = 4'b0010;
  localparam dir_t DIR_W = 4'b0100;
  localparam dir_t DIR_S = 4'b1000;

  typedef enum logic [2:0] {
    IDLE,
    CHK_NEW,
    WAIT_NEW,
    CHK_CUR,
    WAIT_CUR,
    STEP
  } state_t;

  // Coordinates are carried 8 bits wide; callers truncate to the grid width.
  typedef struct packed {
    logic [7:0] x;
    logic [7:0] y;
  } cell_t;

  // Neighbour of (x, y) in direction dir. Grid sizes are powers of two, so
  // masking gives the wrap-around tunnel. A zero or unknown direction
  // returns the cell itself.
  function automatic cell_t next_cell(input logic [7:0] x, input logic [7:0] y,
                                      input dir_t dir, input int grid_w, input int grid_h);
    logic [7:0] mx;
    logic [7:0] my;
    cell_t      c;
    mx  = 8'(grid_w - 1);
    my  = 8'(grid_h - 1);
    c.x = x;
    c.y = y;
    case (dir)
      DIR_N:   c.y = (y - 8'd1) & my;
      DIR_S:   c.y = (y + 8'd1) & my;
      DIR_E:   c.x = (x + 8'd1) & mx;
      DIR_W:   c.x = (x - 8'd1) & mx;
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/pacman_move_ctrl_dir_sync.sv
// Brings the keypad direction register into clk, filters it and holds the last valid request.
// Latency: 4 clk from a dir_req change to pending (2 sync flops, 1 stability flop, 1 capture).
// Backpressure: none; pending always reflects the newest stable one-hot request.
// Ports: clk, reset (async, active-high), dir_req (raw keypad register), pending (filtered direction).
module dir_sync
  import pacman_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  dir_t dir_req,
  output dir_t pending
);

  dir_t sync1;
  dir_t sync2;
  dir_t sync2_q;
  logic stable;
  logic one_hot;

  // Same synchronised value on two consecutive clks filters out a
  // mid-transition sample of the multi-bit register.
  assign stable  = (sync2 == sync2_q);
  assign one_hot = (sync2 != 4'b0000) && ((sync2 & (sync2 - 4'd1)) == 4'b0000);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1   <= 4'b0000;
      sync2   <= 4'b0000;
      sync2_q <= 4'b0000;
      pending <= 4'b0000;
    end else begin
      sync1   <= dir_req;
      sync2   <= sync1;
      sync2_q <= sync2;
      if (stable && one_hot) begin
        pending <= sync2;
      end
    end
  end

endmodule

// File: rtl/pacman_move_ctrl.sv
// Steps Pac-Man one cell per game tick, preferring the newest keypad direction over the current heading.
// Latency: tick to move_done is 3 clk plus the ack wait of each wall check (5 clk with ack one cycle after req).
// Backpressure: wall lookup over req/ack with timeout; ticks arriving while a step is in flight are dropped (overrun).
// Ports: clk, reset; dir_req, tick in; wall_req/wall_x/wall_y out, wall_ack/wall_hit in;
//        pos_x, pos_y, cur_dir, move_done, overrun, timeout_err out.
module pacman_move_ctrl
  import pacman_pkg::*;
#(
  parameter int GRID_W      = 8,
  parameter int GRID_H      = 8,
  parameter int START_X     = 3,
  parameter int START_Y     = 4,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [3:0]                dir_req,
  input  logic                      tick,
  output logic                      wall_req,
  output logic [$clog2(GRID_W)-1:0] wall_x,
  output logic [$clog2(GRID_H)-1:0] wall_y,
  input  logic                      wall_ack,
  input  logic                      wall_hit,
  output logic [$clog2(GRID_W)-1:0] pos_x,
  output logic [$clog2(GRID_H)-1:0] pos_y,
  output logic [3:0]                cur_dir,
  output logic                      move_done,
  output logic                      overrun,
  output logic                      timeout_err
);

  localparam int XW = $clog2(GRID_W);
  localparam int YW = $clog2(GRID_H);
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_MAX = TW'(ACK_TIMEOUT);

  state_t        state;
  dir_t          pending;
  dir_t          chk_dir;
  logic [TW-1:0] tmo_cnt;
  cell_t         new_cell;
  cell_t         cur_cell;
  logic          resolved;

  dir_sync u_dir_sync (
    .clk     (clk),
    .reset   (reset),
    .dir_req (dir_req),
    .pending (pending)
  );

  // chk_dir is frozen at the tick so a key change mid-check cannot make the
  // heading differ from the cell that was actually tested.
  assign new_cell = next_cell(8'(pos_x), 8'(pos_y), chk_dir, GRID_W, GRID_H);
  assign cur_cell = next_cell(8'(pos_x), 8'(pos_y), cur_dir, GRID_W, GRID_H);

  // A timeout resolves the check exactly like a wall hit.
  assign resolved = wall_ack || (tmo_cnt == TMO_MAX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      pos_x       <= XW'(START_X);
      pos_y       <= YW'(START_Y);
      cur_dir     <= 4'b0000;
      chk_dir     <= 4'b0000;
      wall_req    <= 1'b0;
      wall_x      <= '0;
      wall_y      <= '0;
      move_done   <= 1'b0;
      overrun     <= 1'b0;
      timeout_err <= 1'b0;
      tmo_cnt     <= '0;
    end else begin
      move_done <= 1'b0;
      if (tick && state != IDLE) begin
        overrun <= 1'b1;
      end
      case (state)
        IDLE: begin
          // The move_done cycle belongs to the previous step; its tick is dropped.
          if (tick && !move_done) begin
            if (pending != 4'b0000 && pending != cur_dir) begin
              chk_dir <= pending;
              state   <= CHK_NEW;
            end else if (cur_dir != 4'b0000) begin
              state <= CHK_CUR;
            end else begin
              move_done <= 1'b1;
            end
          end
        end
        CHK_NEW: begin
          wall_x   <= new_cell.x[XW-1:0];
          wall_y   <= new_cell.y[YW-1:0];
          wall_req <= 1'b1;
          tmo_cnt  <= '0;
          state    <= WAIT_NEW;
        end
        CHK_CUR: begin
          wall_x   <= cur_cell.x[XW-1:0];
          wall_y   <= cur_cell.y[YW-1:0];
          wall_req <= 1'b1;
          tmo_cnt  <= '0;
          state    <= WAIT_CUR;
        end
        WAIT_NEW: begin
          if (resolved) begin
            wall_req <= 1'b0;
            if (!wall_ack) begin
              timeout_err <= 1'b1;
            end
            if (wall_ack && !wall_hit) begin
              cur_dir <= chk_dir;
              state   <= STEP;
            end else if (cur_dir != 4'b0000) begin
              state <= CHK_CUR;
            end else begin
              move_done <= 1'b1;
              state     <= IDLE;
            end
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        WAIT_CUR: begin
          if (resolved) begin
            wall_req <= 1'b0;
            if (!wall_ack) begin
              timeout_err <= 1'b1;
            end
            if (wall_ack && !wall_hit) begin
              state <= STEP;
            end else begin
              cur_dir   <= 4'b0000;
              move_done <= 1'b1;
              state     <= IDLE;
            end
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        STEP: begin
          pos_x     <= cur_cell.x[XW-1:0];
          pos_y     <= cur_cell.y[YW-1:0];
          move_done <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pacman_move_ctrl.sv
// Directed bench for pacman_move_ctrl: drives ticks, answers wall lookups and checks position/heading.
// Latency: n/a.
// Backpressure: wall_ack is returned one cycle after wall_req is first seen, or withheld to force a timeout.
module tb_pacman_move_ctrl;

  logic       clk;
  logic       reset;
  logic [3:0] dir_req;
  logic       tick;
  logic       wall_req;
  logic [2:0] wall_x;
  logic [2:0] wall_y;
  logic       wall_ack;
  logic       wall_hit;
  logic [2:0] pos_x;
  logic [2:0] pos_y;
  logic [3:0] cur_dir;
  logic       move_done;
  logic       overrun;
  logic       timeout_err;

  int checks = 0;
  int errors = 0;

  int         lat;
  int         nq;
  logic [2:0] qx0, qy0, qx1, qy1;

  pacman_move_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .dir_req     (dir_req),
    .tick        (tick),
    .wall_req    (wall_req),
    .wall_x      (wall_x),
    .wall_y      (wall_y),
    .wall_ack    (wall_ack),
    .wall_hit    (wall_hit),
    .pos_x       (pos_x),
    .pos_y       (pos_y),
    .cur_dir     (cur_dir),
    .move_done   (move_done),
    .overrun     (overrun),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic settle();
    repeat (6) @(negedge clk);
  endtask

  // One game step: pulse tick, answer up to n_acks lookups (hit value
  // hits[k] for the k-th), optionally re-tick at cycle extra_at, and record
  // the first two queried cells and the tick-to-move_done latency.
  task automatic tick_step(input int n_acks, input logic [1:0] hits, input int extra_at);
    bit seen;
    bit ackdue;
    bit done;
    int k;
    seen   = 0;
    ackdue = 0;
    done   = 0;
    k      = 0;
    nq     = 0;
    lat    = -1;
    @(negedge clk);
    tick = 1'b1;
    for (int cyc = 1; cyc <= 80; cyc++) begin
      @(negedge clk);
      tick     = (cyc == extra_at);
      wall_ack = 1'b0;
      wall_hit = 1'b0;
      if (move_done) begin
        done = 1;
        lat  = cyc;
        break;
      end
      if (wall_req) begin
        if (!seen) begin
          seen   = 1;
          ackdue = 1;
          if (nq == 0) begin qx0 = wall_x; qy0 = wall_y; end
          else if (nq == 1) begin qx1 = wall_x; qy1 = wall_y; end
          nq++;
        end else if (ackdue && k < n_acks) begin
          wall_ack = 1'b1;
          wall_hit = hits[k];
          ackdue   = 0;
          k++;
        end
      end else begin
        seen = 0;
      end
    end
    tick     = 1'b0;
    wall_ack = 1'b0;
    wall_hit = 1'b0;
    chk("move_done_seen", 32'(done), 32'd1);
  endtask

  initial begin
    reset    = 1'b1;
    dir_req  = 4'b0000;
    tick     = 1'b0;
    wall_ack = 1'b0;
    wall_hit = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Reset state
    chk("rst_pos_x", pos_x, 3);
    chk("rst_pos_y", pos_y, 4);
    chk("rst_cur_dir", cur_dir, 4'b0000);
    chk("rst_wall_req", wall_req, 0);
    chk("rst_wall_xy", {wall_x, wall_y}, 0);
    chk("rst_flags", {move_done, overrun, timeout_err}, 0);

    // 1: nothing pending, stopped -> immediate move_done, no lookup
    tick_step(0, 2'b00, 0);
    chk("t1_latency", lat, 1);
    chk("t1_no_req", nq, 0);
    chk("t1_pos", {pos_x, pos_y}, {3'd3, 3'd4});

    // 2: request East, free cell
    dir_req = 4'b0010;
    settle();
    tick_step(1, 2'b00, 0);
    chk("t2_query", {qx0, qy0}, {3'd4, 3'd4});
    chk("t2_latency", lat, 5);
    chk("t2_pos", {pos_x, pos_y}, {3'd4, 3'd4});
    chk("t2_dir", cur_dir, 4'b0010);

    // 3: North blocked, fall back to East heading
    dir_req = 4'b0001;
    settle();
    tick_step(2, 2'b01, 0);
    chk("t3_nq", nq, 2);
    chk("t3_query_new", {qx0, qy0}, {3'd4, 3'd3});
    chk("t3_query_cur", {qx1, qy1}, {3'd5, 3'd4});
    chk("t3_pos", {pos_x, pos_y}, {3'd5, 3'd4});
    chk("t3_dir", cur_dir, 4'b0010);

    // 4: East wrap from x=7, then North wrap from y=0
    dir_req = 4'b0010;
    settle();
    for (int i = 0; i < 2; i++) tick_step(1, 2'b00, 0);
    chk("t4_pos_7_4", {pos_x, pos_y}, {3'd7, 3'd4});
    tick_step(1, 2'b00, 0);
    chk("t4_query_wrap_x", {qx0, qy0}, {3'd0, 3'd4});
    chk("t4_pos_wrap_x", {pos_x, pos_y}, {3'd0, 3'd4});
    for (int i = 0; i < 3; i++) tick_step(1, 2'b00, 0);
    dir_req = 4'b0001;
    settle();
    for (int i = 0; i < 4; i++) tick_step(1, 2'b00, 0);
    chk("t4_pos_3_0", {pos_x, pos_y}, {3'd3, 3'd0});
    chk("t4_dir_n", cur_dir, 4'b0001);
    tick_step(1, 2'b00, 0);
    chk("t4_query_wrap_y", {qx0, qy0}, {3'd3, 3'd7});
    chk("t4_pos_wrap_y", {pos_x, pos_y}, {3'd3, 3'd7});

    // 5: no acks -> both checks time out; second tick mid-wait -> overrun
    dir_req = 4'b0100;
    settle();
    chk("t5_pre_flags", {overrun, timeout_err}, 2'b00);
    tick_step(0, 2'b00, 5);
    chk("t5_nq", nq, 2);
    chk("t5_query_new", {qx0, qy0}, {3'd2, 3'd7});
    chk("t5_query_cur", {qx1, qy1}, {3'd3, 3'd6});
    chk("t5_wall_req", wall_req, 0);
    chk("t5_timeout_err", timeout_err, 1);
    chk("t5_overrun", overrun, 1);
    chk("t5_dir", cur_dir, 4'b0000);
    chk("t5_pos", {pos_x, pos_y}, {3'd3, 3'd7});

    // 6: multi-hot ignored; async reset mid-handshake
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    dir_req = 4'b0010;
    settle();
    dir_req = 4'b0110;
    settle();
    @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    for (int i = 0; i < 10 && !wall_req; i++) @(negedge clk);
    chk("t6_req_up", wall_req, 1);
    chk("t6_query", {wall_x, wall_y}, {3'd4, 3'd4});
    reset = 1'b1;
    #1;
    chk("t6_async_req_drop", wall_req, 0);
    chk("t6_async_pos", {pos_x, pos_y}, {3'd3, 3'd4});
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
